// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// The master drives operands and result acceptance; the slave is the adder.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor. WIDTH-bit operands are split into
// STAGES chunks of CHUNK bits; stage k resolves chunk k using the carry
// registered by stage k-1. Each stage carries forward only the operand chunks
// still to be added and the sum chunks already finished. A stall (result
// valid but not taken) freezes every stage at once. Data registers load only
// when a valid operation enters them, so outputs keep their last result while
// bubbles pass through.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic            clk,
  input logic            rst_n,
  pipelined_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  logic             stall;
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is A + ~B + 1; the external carry-in is ignored in that mode.
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c0    = bus.sub | bus.cin;

  assign stall        = bus.out_valid && !bus.out_ready;
  assign adv          = !stall;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RW = (STAGES - k) * CHUNK;  // operand bits not yet added
    localparam int SW = (k + 1) * CHUNK;       // sum bits finished after this stage

    logic [RW-1:0]  a_in;
    logic [RW-1:0]  b_in;
    logic           c_in;
    logic           v_in;
    logic [CHUNK:0] add;
    logic [SW-1:0]  s_next;
    logic           v_q;
    logic           c_q;
    logic [SW-1:0]  s_q;

    if (k == 0) begin : g_head
      assign a_in   = bus.a;
      assign b_in   = b_eff;
      assign c_in   = c0;
      assign v_in   = bus.in_valid;
      assign s_next = add[CHUNK-1:0];
    end else begin : g_body
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
      assign c_in   = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_next = {add[CHUNK-1:0], g_stage[k-1].s_q};
    end

    assign add = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

    // Valid bit advances every unstalled edge, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_in;
      end
    end

    // Partial sum and chunk carry load only for a real operation.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (adv && v_in) begin
        s_q <= s_next;
        c_q <= add[CHUNK];
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-CHUNK-1:0] a_q;
      logic [RW-CHUNK-1:0] b_q;

      // Forward the operand chunks that later stages still need.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && v_in) begin
          a_q <= a_in[RW-1:CHUNK];
          b_q <= b_in[RW-1:CHUNK];
        end
      end
    end else begin : g_last
      logic cm_q;

      // Carry into the MSB recovered as a ^ b ^ sum at that bit; used for overflow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cm_q <= 1'b0;
        end else if (adv && v_in) begin
          cm_q <= a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ add[CHUNK-1];
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.sum       = g_stage[STAGES-1].s_q;
  assign bus.carry     = g_stage[STAGES-1].c_q;
  assign bus.overflow  = g_stage[STAGES-1].g_last.cm_q ^ g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three instances (STAGES = 4, 1, 16; WIDTH = 16)
// share one operand stream. A scoreboard predicts, per instance, when each
// accepted operation must appear and what its result is, from plain integer
// arithmetic; one negedge process compares every cycle.
module tb_pipelined_adder;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] in_valid_v;
  logic [15:0]  op_a, op_b;
  logic         op_cin, op_sub;
  logic         out_ready;
  wire  [N-1:0] in_ready_v, out_valid_v, carry_v, ovf_v;
  wire  [15:0]  sum_v [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    pipelined_adder_if #(.WIDTH(16)) bus ();
    assign bus.in_valid  = in_valid_v[g];
    assign bus.a         = op_a;
    assign bus.b         = op_b;
    assign bus.cin       = op_cin;
    assign bus.sub       = op_sub;
    assign bus.out_ready = out_ready;
    assign in_ready_v[g]  = bus.in_ready;
    assign out_valid_v[g] = bus.out_valid;
    assign sum_v[g]       = bus.sum;
    assign carry_v[g]     = bus.carry;
    assign ovf_v[g]       = bus.overflow;
    pipelined_adder #(.WIDTH(16), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  end

  function automatic int stages_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 16;
  endfunction

  // Golden result {overflow, carry, sum} straight from the arithmetic rules.
  function automatic logic [17:0] golden(input logic [15:0] a, input logic [15:0] b,
                                         input logic ci, input logic sb);
    int ua, ub, full, sa, sbv, sres;
    logic ov;
    ua = int'(a);
    ub = int'(b);
    if (sb) full = ua + (65535 - ub) + 1;
    else    full = ua + ub + (ci ? 1 : 0);
    sa  = $signed(a);
    sbv = $signed(b);
    sres = sb ? (sa - sbv) : (sa + sbv + (ci ? 1 : 0));
    ov = (sres > 32767) || (sres < -32768);
    return {ov, full[16], full[15:0]};
  endfunction

  typedef struct {
    int          dut;
    logic [16:0] res;
    logic        ov;
    int          due;
    bit          lit;
    logic [16:0] lres;
    logic        lov;
  } ent_t;

  ent_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          n_timeouts;
  bit          end_req;
  bit          end_done = 1'b0;
  bit          cur_lit;
  logic [16:0] cur_lres;
  logic        cur_lov;
  logic [16:0] hold_res [N];
  logic        hold_ov  [N];
  bit          rnd_ready;
  int          stall_left;

  task automatic chk(input string nm, input int d, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d(S=%0d) cyc=%0d got=%h want=%h", nm, d, stages_of(d), cyc, got, exp);
  endtask

  // Single compare process: reset state, valid timing, results, hold and stall behaviour.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      sb.delete();
      for (int i = 0; i < N; i++) begin
        chk("reset_out_valid", i, {16'd0, out_valid_v[i]}, 17'd0);
        chk("reset_in_ready", i, {16'd0, in_ready_v[i]}, 17'd1);
        chk("reset_carry_sum", i, {carry_v[i], sum_v[i]}, 17'd0);
        chk("reset_overflow", i, {16'd0, ovf_v[i]}, 17'd0);
        hold_res[i] = '0;
        hold_ov[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        int  fi;
        bit  exp_v;
        fi = -1;
        for (int k = 0; k < sb.size(); k++) begin
          if (sb[k].dut == i) begin
            fi = k;
            break;
          end
        end
        exp_v = 1'b0;
        if (fi >= 0) exp_v = (sb[fi].due <= cyc);
        chk("out_valid", i, {16'd0, out_valid_v[i]}, {16'd0, exp_v});
        chk("in_ready", i, {16'd0, in_ready_v[i]}, {16'd0, !(exp_v && !out_ready)});
        if (exp_v) begin
          chk("carry_sum", i, {carry_v[i], sum_v[i]}, sb[fi].res);
          chk("overflow", i, {16'd0, ovf_v[i]}, {16'd0, sb[fi].ov});
          if (sb[fi].lit) begin
            chk("literal_carry_sum", i, {carry_v[i], sum_v[i]}, sb[fi].lres);
            chk("literal_overflow", i, {16'd0, ovf_v[i]}, {16'd0, sb[fi].lov});
          end
          hold_res[i] = sb[fi].res;
          hold_ov[i]  = sb[fi].ov;
          if (out_ready) begin
            sb.delete(fi);
          end else begin
            for (int k = fi + 1; k < sb.size(); k++)
              if (sb[k].dut == i) sb[k].due = sb[k].due + 1;
          end
        end else begin
          chk("hold_carry_sum", i, {carry_v[i], sum_v[i]}, hold_res[i]);
          chk("hold_overflow", i, {16'd0, ovf_v[i]}, {16'd0, hold_ov[i]});
        end
        if (in_valid_v[i] && in_ready_v[i]) begin
          ent_t        e;
          logic [17:0] gv;
          gv     = golden(op_a, op_b, op_cin, op_sub);
          e.dut  = i;
          e.res  = gv[16:0];
          e.ov   = gv[17];
          e.due  = cyc + stages_of(i);
          e.lit  = cur_lit;
          e.lres = cur_lres;
          e.lov  = cur_lov;
          sb.push_back(e);
        end
      end
      if (end_req && !end_done) begin
        chk("drain_empty", 0, 17'(sb.size()), 17'd0);
        chk("send_timeouts", 0, 17'(n_timeouts), 17'd0);
        end_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall_left > 0) begin
      out_ready  = 1'b0;
      stall_left = stall_left - 1;
    end else if (rnd_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  endtask

  // Offer one operation to every instance, holding it until each has taken it.
  task automatic send_op(input logic [15:0] a_i, input logic [15:0] b_i, input logic cin_i,
                         input logic sub_i, input bit lit_i, input logic [16:0] lres_i,
                         input logic lov_i);
    logic [N-1:0] taken, acc;
    int n;
    op_a     = a_i;
    op_b     = b_i;
    op_cin   = cin_i;
    op_sub   = sub_i;
    cur_lit  = lit_i;
    cur_lres = lres_i;
    cur_lov  = lov_i;
    taken    = '0;
    n        = 0;
    while (taken != {N{1'b1}} && n < 100) begin
      in_valid_v = ~taken;
      @(negedge clk);
      acc = in_valid_v & in_ready_v;
      tick();
      taken = taken | acc;
      n++;
    end
    in_valid_v = '0;
    cur_lit    = 1'b0;
    if (taken != {N{1'b1}}) n_timeouts++;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid_v = '0;
    op_a       = '0;
    op_b       = '0;
    op_cin     = 1'b0;
    op_sub     = 1'b0;
    out_ready  = 1'b1;
    rnd_ready  = 1'b0;
    stall_left = 0;
    end_req    = 1'b0;
    n_timeouts = 0;
    cur_lit    = 1'b0;
    cur_lres   = '0;
    cur_lov    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();

    // Directed vectors with hand-computed {carry,sum} and overflow.
    send_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b1, 16'h0000}, 1'b0);
    send_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b0, 16'h8000}, 1'b1);
    send_op(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1, {1'b0, 16'hFFFE}, 1'b0);
    send_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, {1'b1, 16'h7FFF}, 1'b1);
    send_op(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1, {1'b0, 16'hFFFE}, 1'b0);
    send_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, {1'b0, 16'h5556}, 1'b0);
    repeat (20) tick();

    // Back-to-back stream, then a 3-cycle stall with the pipe full.
    for (int i = 0; i < 8; i++)
      send_op(16'((i * 16'h2345) ^ 16'h0F0F), 16'(i * 16'h1111), i[1], i[0], 1'b0, '0, 1'b0);
    out_ready  = 1'b0;
    stall_left = 2;
    for (int i = 8; i < 12; i++)
      send_op(16'((i * 16'h2345) ^ 16'h0F0F), 16'(i * 16'h1111), i[1], i[0], 1'b0, '0, 1'b0);
    repeat (20) tick();

    // Asynchronous reset with three operations in flight.
    for (int i = 0; i < 3; i++)
      send_op(16'(16'hA000 + i), 16'h0F00, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (25) tick();

    // Random operands with random result acceptance.
    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++)
      send_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (30) tick();

    end_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
